// File: rtl/idma_desc64_submit_arbiter.sv
// Round-robin arbiter that merges per-port descriptor submissions into one
// registered output slot and routes in-order completions back as per-port irqs.
module idma_desc64_submit_arbiter #(
  parameter int unsigned NumPorts       = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TrackDepth     = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumPorts-1:0]          req_valid_i,
  output logic [NumPorts-1:0]          req_ready_o,
  input  logic [NumPorts-1:0][63:0]    req_addr_i,
  output logic                         desc_valid_o,
  input  logic                         desc_ready_i,
  output logic [63:0]                  desc_addr_o,
  input  logic                         done_i,
  output logic [NumPorts-1:0]          irq_o,
  output logic [NumPorts-1:0][3:0]     outstanding_o,
  output logic                         error_o
);

  localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned PtrW = $clog2(TrackDepth);
  localparam int unsigned CntW = PtrW + 1;

  logic [IdxW-1:0]     last_grant_q;
  logic [IdxW-1:0]     grant_idx;
  logic [IdxW-1:0]     head_idx;
  logic                grant_vld;
  logic                slot_free;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [NumPorts-1:0] eligible;

  logic [IdxW-1:0]     track_mem [TrackDepth];
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [CntW-1:0]     count_q;

  assign slot_free  = !desc_valid_o || desc_ready_i;
  assign fifo_full  = (count_q == CntW'(TrackDepth));
  assign fifo_empty = (count_q == '0);
  assign push       = grant_vld;
  assign pop        = done_i && !fifo_empty;
  assign head_idx   = track_mem[rd_ptr_q];

  // Eligibility uses registered occupancy only, so a same-cycle pop never frees a slot.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < int'(NumPorts); p++) begin
      eligible[p] = req_valid_i[p] && (outstanding_o[p] < 4'(MaxOutstanding)) &&
                    !fifo_full && slot_free;
    end
  end

  always_comb begin : arbitrate
    int cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 1; i <= int'(NumPorts); i++) begin
      cand = int'(last_grant_q) + i;
      if (cand >= int'(NumPorts)) cand = cand - int'(NumPorts);
      if (!grant_vld && !rst_i && eligible[IdxW'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = IdxW'(cand);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_vld) req_ready_o[grant_idx] = 1'b1;
  end

  // Output slot, tracking pointers, per-port counters and completion pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      desc_valid_o  <= 1'b0;
      desc_addr_o   <= '0;
      last_grant_q  <= IdxW'(NumPorts - 1);
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      irq_o         <= '0;
      error_o       <= 1'b0;
      outstanding_o <= '0;
    end else begin
      if (push) begin
        desc_valid_o <= 1'b1;
        desc_addr_o  <= req_addr_i[grant_idx];
        last_grant_q <= grant_idx;
        wr_ptr_q     <= wr_ptr_q + PtrW'(1);
      end else if (desc_ready_i) begin
        desc_valid_o <= 1'b0;
        desc_addr_o  <= '0;
      end

      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);

      irq_o <= '0;
      if (pop) irq_o[head_idx] <= 1'b1;
      if (done_i && fifo_empty) error_o <= 1'b1;

      for (int p = 0; p < int'(NumPorts); p++) begin
        case ({push && (grant_idx == IdxW'(p)), pop && (head_idx == IdxW'(p))})
          2'b10:   outstanding_o[p] <= outstanding_o[p] + 4'd1;
          2'b01:   outstanding_o[p] <= outstanding_o[p] - 4'd1;
          default: outstanding_o[p] <= outstanding_o[p];
        endcase
      end
    end
  end

  // Owner indices are plain data; the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (push) track_mem[wr_ptr_q] <= grant_idx;
  end

endmodule

// File: tb/tb_idma_desc64_submit_arbiter.sv
// Directed plus randomized bench for idma_desc64_submit_arbiter, checked
// cycle by cycle against a queue-based model of the arbitration rules.
module tb_idma_desc64_submit_arbiter;

  localparam int N    = 4;
  localparam int MAXO = 4;
  localparam int TD   = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [N-1:0]         rv = '0;
  logic [N-1:0]         req_ready;
  logic [N-1:0][63:0]   addr = '0;
  logic                 desc_valid;
  logic                 dr = 1'b0;
  logic [63:0]          desc_addr;
  logic                 done = 1'b0;
  logic [N-1:0]         irq;
  logic [N-1:0][3:0]    outstanding;
  logic                 error;

  always #5 clk = ~clk;

  idma_desc64_submit_arbiter #(
    .NumPorts(N), .MaxOutstanding(MAXO), .TrackDepth(TD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (rv),
    .req_ready_o  (req_ready),
    .req_addr_i   (addr),
    .desc_valid_o (desc_valid),
    .desc_ready_i (dr),
    .desc_addr_o  (desc_addr),
    .done_i       (done),
    .irq_o        (irq),
    .outstanding_o(outstanding),
    .error_o      (error)
  );

  // Reference model state
  bit          m_sv;
  logic [63:0] m_sa;
  int          m_last;
  int          m_q[$];
  int          m_out[N];
  logic [N-1:0] m_irq;
  bit          m_err;
  int          mg;
  logic [N-1:0] rdy_s;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sv   = 0;
    m_sa   = '0;
    m_last = N - 1;
    m_q.delete();
    for (int p = 0; p < N; p++) m_out[p] = 0;
    m_irq  = '0;
    m_err  = 0;
  endtask

  task automatic check_regs();
    chk("desc_valid", desc_valid, m_sv);
    if (m_sv) chk("desc_addr", desc_addr, m_sa);
    chk("irq", irq, m_irq);
    chk("error", error, m_err);
    for (int p = 0; p < N; p++) chk("outstanding", outstanding[p], m_out[p]);
  endtask

  task automatic cyc(input logic [N-1:0] v, input bit d_r, input bit dn);
    int h;
    @(negedge clk);
    rv   = v;
    dr   = d_r;
    done = dn;
    for (int p = 0; p < N; p++) addr[p] = {$urandom(), $urandom()};
    #1;
    mg = -1;
    if (!m_sv || d_r) begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_last + i) % N;
        if (mg < 0 && v[c] && m_out[c] < MAXO && m_q.size() < TD) mg = c;
      end
    end
    rdy_s = req_ready;
    chk("req_ready", req_ready, (mg >= 0) ? (64'd1 << mg) : 64'd0);
    @(posedge clk);
    m_irq = '0;
    if (dn) begin
      if (m_q.size() > 0) begin
        h = m_q.pop_front();
        m_out[h]--;
        m_irq[h] = 1'b1;
      end else begin
        m_err = 1;
      end
    end
    if (mg >= 0) begin
      m_q.push_back(mg);
      m_out[mg]++;
      m_last = mg;
      m_sv   = 1;
      m_sa   = addr[mg];
    end else if (d_r) begin
      m_sv = 0;
    end
    #1;
    check_regs();
  endtask

  // Reset is raised between edges so the clearing must be asynchronous.
  task automatic do_reset();
    @(negedge clk);
    rv   = '1;
    done = 1'b0;
    dr   = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_desc_valid", desc_valid, 0);
    chk("rst_desc_addr", desc_addr, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_irq", irq, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_error", error, 0);
    model_reset();
    @(negedge clk);
    rv  = '0;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    for (int k = 0; k < 5; k++) begin
      cyc(4'hF, 1, 0);
      chk("rr_order", rdy_s, 64'd1 << (k % N));
      chk("rr_valid", desc_valid, 1);
    end

    do_reset();
    cyc(4'h2, 1, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(4'h2, 0, 0);
      chk("stall_ready", rdy_s, 0);
    end
    cyc(4'h0, 1, 0);
    chk("drain_valid", desc_valid, 0);
    chk("drain_outstanding", outstanding[1], 1);

    do_reset();
    for (int k = 0; k < 4; k++) cyc(4'h4, 1, 0);
    chk("limit_count", outstanding[2], 4);
    cyc(4'h4, 1, 0);
    chk("limit_ready", rdy_s, 0);
    cyc(4'h4, 1, 1);
    chk("limit_irq", irq, 4'h4);
    cyc(4'h4, 1, 0);
    chk("limit_fifth", rdy_s, 4'h4);

    do_reset();
    cyc(4'h8, 1, 0);
    cyc(4'h1, 1, 0);
    cyc(4'h8, 1, 0);
    cyc(4'h0, 1, 1);
    chk("order_irq0", irq, 4'h8);
    cyc(4'h0, 1, 1);
    chk("order_irq1", irq, 4'h1);
    cyc(4'h0, 1, 1);
    chk("order_irq2", irq, 4'h8);
    chk("order_empty", outstanding, 0);

    do_reset();
    cyc(4'h0, 1, 1);
    chk("spurious_error", error, 1);
    chk("spurious_counts", outstanding, 0);
    cyc(4'h2, 1, 0);
    cyc(4'h2, 1, 1);
    chk("pushpop_ready", rdy_s, 4'h2);
    chk("pushpop_count", outstanding[1], 1);
    chk("pushpop_irq", irq, 4'h2);

    for (int k = 0; k < 3; k++) cyc(4'hF, 0, 0);
    cyc(4'hF, 1, 0);
    cyc(4'hF, 1, 0);
    do_reset();
    cyc(4'hF, 1, 0);
    chk("post_rst_grant", rdy_s, 4'h1);
    for (int k = 0; k < 3; k++) cyc(4'h0, 1, 1);

    for (int k = 0; k < 250; k++)
      cyc(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
    for (int k = 0; k < 250; k++)
      cyc(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
